// File: rtl/seq_det_event_counter.sv
// =============================================================================
// seq_det_event_counter : edge-detects the 1010 detector output, keeps a
// saturating total, per-window counts and a held threshold interrupt.
// Revision 1.0
// =============================================================================
`default_nettype none

module seq_det_event_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             clr,
    input  logic             ack,
    output logic             ev,
    output logic [CNT_W-1:0] total_cnt,
    output logic             total_sat,
    output logic [CNT_W-1:0] last_cnt,
    output logic             irq,
    output logic             overrun
);

    localparam int               WC_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ALERT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             z_q, z_d;
    logic             ev_q, ev_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             total_sat_q, total_sat_d;
    logic [WC_W-1:0]  wc_q, wc_d;
    logic [CNT_W-1:0] wn_q, wn_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             overrun_q, overrun_d;

    logic             rise;
    logic             boundary;
    logic             hit;
    logic [CNT_W-1:0] wn_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            z_q         <= 1'b0;
            ev_q        <= 1'b0;
            total_q     <= '0;
            total_sat_q <= 1'b0;
            wc_q        <= '0;
            wn_q        <= '0;
            last_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            ev_q        <= ev_d;
            total_q     <= total_d;
            total_sat_q <= total_sat_d;
            wc_q        <= wc_d;
            wn_q        <= wn_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rise        = z & ~z_q;
        boundary    = (wc_q == WC_LAST);
        // An event landing in the boundary cycle still belongs to the closing window.
        wn_inc      = (rise && (wn_q != CNT_MAX)) ? wn_q + 1'b1 : wn_q;
        hit         = boundary && (wn_inc >= THRESH_C);

        z_d         = z;
        ev_d        = rise;
        total_d     = (rise && (total_q != CNT_MAX)) ? total_q + 1'b1 : total_q;
        total_sat_d = total_sat_q | (total_d == CNT_MAX);
        wc_d        = boundary ? '0 : wc_q + 1'b1;
        wn_d        = boundary ? '0 : wn_inc;
        last_d      = boundary ? wn_inc : last_q;
        state_d     = state_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ALERT;
                end
            end
            S_ALERT: begin
                // A fresh hit outranks a simultaneous acknowledge.
                if (hit) begin
                    overrun_d = 1'b1;
                end else if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            state_d     = S_IDLE;
            z_d         = 1'b0;
            ev_d        = 1'b0;
            total_d     = '0;
            total_sat_d = 1'b0;
            wc_d        = '0;
            wn_d        = '0;
            last_d      = '0;
            overrun_d   = 1'b0;
        end
    end

    assign ev        = ev_q;
    assign total_cnt = total_q;
    assign total_sat = total_sat_q;
    assign last_cnt  = last_q;
    assign irq       = (state_q == S_ALERT);
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_event_counter.sv
// =============================================================================
// tb_seq_det_event_counter : directed stimulus, cycle-by-cycle model compare.
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_seq_det_event_counter;

    localparam int CNT_W  = 8;
    localparam int WINDOW = 16;
    localparam int THRESH = 3;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             z   = 1'b0;
    logic             clr = 1'b0;
    logic             ack = 1'b0;
    logic             ev;
    logic [CNT_W-1:0] total_cnt;
    logic             total_sat;
    logic [CNT_W-1:0] last_cnt;
    logic             irq;
    logic             overrun;

    int n_checks = 0;
    int n_pass   = 0;

    seq_det_event_counter #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .z         (z),
        .clr       (clr),
        .ack       (ack),
        .ev        (ev),
        .total_cnt (total_cnt),
        .total_sat (total_sat),
        .last_cnt  (last_cnt),
        .irq       (irq),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: counts events and cycles since reset/clr as plain integers.
    int m_events = 0;
    int m_win    = 0;
    int m_k      = 0;
    int m_last   = 0;
    bit m_zprev  = 0;
    bit m_ev     = 0;
    bit m_irq    = 0;
    bit m_ovr    = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            m_events = 0; m_win = 0; m_k = 0; m_last = 0;
            m_zprev = 0; m_ev = 0; m_irq = 0; m_ovr = 0;
        end else begin
            m_ev    = z && !m_zprev;
            m_zprev = z;
            if (m_ev) begin
                m_events++;
                m_win++;
            end
            if ((m_k % WINDOW) == WINDOW - 1) begin
                m_last = (m_win > MAXV) ? MAXV : m_win;
                m_win  = 0;
                if (m_last >= THRESH) begin
                    if (m_irq) m_ovr = 1;
                    m_irq = 1;
                end else if (ack) begin
                    m_irq = 0;
                end
            end else if (ack) begin
                m_irq = 0;
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        chk("ev",        ev,        m_ev);
        chk("total_cnt", total_cnt, (m_events > MAXV) ? MAXV : m_events);
        chk("total_sat", total_sat, m_events >= MAXV);
        chk("last_cnt",  last_cnt,  m_last);
        chk("irq",       irq,       m_irq);
        chk("overrun",   overrun,   m_ovr);
    end

    task automatic drive(input logic zv, input logic av, input logic cv);
        z   = zv;
        ack = av;
        clr = cv;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] det_hist = 4'b0000;
    int         det_n    = 0;

    // Upstream Moore 1010 non-overlapping detector; one bit per clock.
    task automatic det_bit(input logic b);
        logic zv;
        det_hist = {det_hist[2:0], b};
        det_n++;
        zv = (det_n >= 4) && (det_hist == 4'b1010);
        if (zv) det_n = 0;
        drive(zv, 1'b0, 1'b0);
    endtask

    logic [8:0] stream_bits = 9'b010101011;

    initial begin
        // Reset held with z toggling
        for (int i = 0; i < 6; i++) begin
            drive(logic'(i % 2), 1'b0, 1'b0);
            chk("rst_ev", ev, 0);
            chk("rst_total", total_cnt, 0);
        end
        z = 1'b0;
        rst = 1'b1;

        // Window 0: detector stream yields two z pulses
        for (int i = 0; i < 9; i++) det_bit(stream_bits[i]);
        chk("stream_ev", ev, 1);
        chk("stream_total", total_cnt, 2);
        idle(6);
        chk("pre_boundary_last", last_cnt, 0);
        idle(1);
        chk("w0_last", last_cnt, 2);
        chk("w0_irq", irq, 0);

        // Window 1: z held high five cycles
        drive(1'b1, 1'b0, 1'b0);
        chk("held_ev", ev, 1);
        chk("held_total", total_cnt, 3);
        drive(1'b1, 1'b0, 1'b0);
        chk("held_ev_once", ev, 0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        idle(11);
        chk("w1_last", last_cnt, 1);
        chk("w1_total", total_cnt, 3);

        // Window 2: three pulses, last one in the boundary cycle
        idle(2);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 1'b0);
        idle(8);
        chk("w2_pre_irq", irq, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("w2_last", last_cnt, 3);
        chk("w2_irq", irq, 1);
        chk("w2_total", total_cnt, 6);
        drive(1'b0, 1'b1, 1'b0);
        chk("ack_irq", irq, 0);
        chk("ack_overrun", overrun, 0);

        // Windows 3 and 4: back-to-back hits, second with ack
        idle(1);
        drive(1'b1, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0);
        idle(9);
        chk("w3_irq", irq, 1);
        chk("w3_last", last_cnt, 3);
        chk("w3_overrun", overrun, 0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0);
        idle(10);
        drive(1'b1, 1'b1, 1'b0);
        chk("w4_irq_hit_ack", irq, 1);
        chk("w4_overrun", overrun, 1);
        chk("w4_total", total_cnt, 12);
        drive(1'b0, 1'b1, 1'b0);
        chk("w4_ack_irq", irq, 0);
        chk("w4_overrun_sticky", overrun, 1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        chk("sat_total", total_cnt, 255);
        chk("sat_flag", total_sat, 1);

        // Clear overrides z
        drive(1'b1, 1'b0, 1'b1);
        chk("clr_total", total_cnt, 0);
        chk("clr_sat", total_sat, 0);
        chk("clr_overrun", overrun, 0);
        chk("clr_irq", irq, 0);
        chk("clr_last", last_cnt, 0);
        chk("clr_ev", ev, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("post_clr_ev", ev, 1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("partial_total", total_cnt, 3);
        drive(1'b0, 1'b0, 1'b1);
        idle(16);
        chk("partial_discard_last", last_cnt, 0);
        chk("partial_discard_irq", irq, 0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        chk("idle_ack_irq", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
